// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - multi-cycle ALU with radix-2 Booth multiply and restoring divide
//
// Purpose: single-issue ALU. Most ops finish at the edge that accepts them.
// MUL and DIV iterate one bit per clock and publish the result when they finish.
//
// Ports:
//   clk          rising-edge clock
//   clr          asynchronous active-high reset
//   start        launch request, accepted only in IDLE
//   ctrl[3:0]    opcode
//   A, B         operands, WIDTH bits each
//   ZHI, ZLO     registered high/low result halves
//   busy         high while MUL/DIV iterate
//   done         one-cycle pulse, new result valid
//   div_by_zero  high with done for a divide by zero
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ZHI,
  output logic [WIDTH-1:0] ZLO,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_SHR = 4'b0100;
  localparam logic [3:0] OP_SHL = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_ROL = 4'b0111;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_NEG = 4'b1010;
  localparam logic [3:0] OP_NOT = 4'b1011;
  localparam logic [3:0] OP_SRA = 4'b1100;
  localparam logic [3:0] OP_XOR = 4'b1101;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state;
  // hi: Booth accumulator (one guard bit so subtracting MIN cannot overflow)
  //     or divide partial remainder.
  // lo: Booth multiplier shifting out / dividend shifting out, quotient in.
  logic [WIDTH:0]   hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;      // multiplicand A, or divisor magnitude |B|
  logic             qm1;       // Booth q(-1) bit
  logic             quo_neg;
  logic             rem_neg;
  logic [SHW-1:0]   cnt;

  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign amt   = B[SHW-1:0];
  // |MIN| is 2^(WIDTH-1), which still fits as an unsigned magnitude.
  assign a_mag = A[WIDTH-1] ? -A : A;
  assign b_mag = B[WIDTH-1] ? -B : B;

  // Single-cycle result, computed straight from the inputs at the accept edge.
  logic [WIDTH-1:0] sc_hi;
  logic [WIDTH-1:0] sc_lo;
  logic [WIDTH-1:0] ror_v;
  logic [WIDTH-1:0] rol_v;

  always_comb begin
    ror_v = '0;
    rol_v = '0;
    // Index arithmetic truncated to SHW bits wraps modulo WIDTH.
    for (int i = 0; i < WIDTH; i++) begin
      ror_v[i] = A[SHW'(i + int'(amt))];
      rol_v[i] = A[SHW'(i - int'(amt))];
    end
  end

  always_comb begin
    sc_hi = '0;
    sc_lo = '0;
    case (ctrl)
      OP_ADD: sc_lo = A + B;
      OP_SUB: sc_lo = A - B;
      OP_DIV: begin
        // Only reaches here with B == 0.
        sc_lo = '1;
        sc_hi = A;
      end
      OP_SHR: sc_lo = A >> amt;
      OP_SHL: sc_lo = A << amt;
      OP_ROR: sc_lo = ror_v;
      OP_ROL: sc_lo = rol_v;
      OP_AND: sc_lo = A & B;
      OP_OR:  sc_lo = A | B;
      OP_NEG: sc_lo = -A;
      OP_NOT: sc_lo = ~A;
      OP_SRA: sc_lo = $signed(A) >>> amt;
      OP_XOR: sc_lo = A ^ B;
      default: begin
        sc_hi = '0;
        sc_lo = '0;
      end
    endcase
  end

  // One Booth step: add/subtract multiplicand, then arithmetic shift right.
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   bsum;
  logic [WIDTH:0]   b_hi;
  logic [WIDTH-1:0] b_lo;

  assign m_ext = {opnd[WIDTH-1], opnd};

  always_comb begin
    case ({lo[0], qm1})
      2'b10:   bsum = hi - m_ext;
      2'b01:   bsum = hi + m_ext;
      default: bsum = hi;
    endcase
    b_hi = {bsum[WIDTH], bsum[WIDTH:1]};
    b_lo = {bsum[0], lo[WIDTH-1:1]};
  end

  // One restoring-division step on magnitudes.
  logic [WIDTH:0]   d_shift;
  logic [WIDTH:0]   d_trial;
  logic [WIDTH:0]   d_hi;
  logic [WIDTH-1:0] d_lo;

  always_comb begin
    d_shift = {hi[WIDTH-1:0], lo[WIDTH-1]};
    d_trial = d_shift - {1'b0, opnd};
    if (d_trial[WIDTH]) begin
      d_hi = d_shift;
      d_lo = {lo[WIDTH-2:0], 1'b0};
    end else begin
      d_hi = d_trial;
      d_lo = {lo[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= IDLE;
      hi          <= '0;
      lo          <= '0;
      opnd        <= '0;
      qm1         <= 1'b0;
      quo_neg     <= 1'b0;
      rem_neg     <= 1'b0;
      cnt         <= '0;
      ZHI         <= '0;
      ZLO         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= '0;
            if (ctrl == OP_MUL) begin
              hi    <= '0;
              lo    <= B;
              qm1   <= 1'b0;
              opnd  <= A;
              busy  <= 1'b1;
              state <= MUL;
            end else if (ctrl == OP_DIV && B != '0) begin
              hi      <= '0;
              lo      <= a_mag;
              opnd    <= b_mag;
              quo_neg <= A[WIDTH-1] ^ B[WIDTH-1];
              rem_neg <= A[WIDTH-1];
              busy    <= 1'b1;
              state   <= DIV;
            end else begin
              ZHI         <= sc_hi;
              ZLO         <= sc_lo;
              done        <= 1'b1;
              div_by_zero <= (ctrl == OP_DIV);
              state       <= DONE;
            end
          end
        end
        MUL: begin
          hi  <= b_hi;
          lo  <= b_lo;
          qm1 <= lo[0];
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            // Last step lands directly in the outputs.
            ZHI   <= b_hi[WIDTH-1:0];
            ZLO   <= b_lo;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DIV: begin
          hi  <= d_hi;
          lo  <= d_lo;
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            // MIN / -1: magnitude quotient 2^(WIDTH-1) negates back to MIN.
            ZLO   <= quo_neg ? -d_lo : d_lo;
            ZHI   <= rem_neg ? -d_hi[WIDTH-1:0] : d_hi[WIDTH-1:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - self-checking bench for multicycle_alu
module tb_multicycle_alu;

  logic        clk;
  logic        clr;
  logic        start;
  logic [3:0]  ctrl;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ZHI;
  logic [31:0] ZLO;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  multicycle_alu dut (
    .clk(clk), .clr(clr), .start(start), .ctrl(ctrl), .A(A), .B(B),
    .ZHI(ZHI), .ZLO(ZLO), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          bcyc;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference model straight from the opcode definitions.
  task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output logic dz, output int lat);
    logic [63:0] dbl;
    longint      p;
    int          q;
    int          r;
    logic [4:0]  s;
    hi = 0; lo = 0; dz = 0; lat = 1;
    s = b[4:0];
    dbl = {a, a};
    case (c)
      4'd0:  lo = a + b;
      4'd1:  lo = a - b;
      4'd2: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {hi, lo} = p;
        lat = 33;
      end
      4'd3: begin
        if (b == 0) begin
          lo = 32'hFFFFFFFF; hi = a; dz = 1;
        end else begin
          lat = 33;
          if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            lo = a; hi = 0;
          end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            lo = q; hi = r;
          end
        end
      end
      4'd4:  lo = a >> s;
      4'd5:  lo = a << s;
      4'd6: begin dbl = dbl >> s; lo = dbl[31:0]; end
      4'd7: begin dbl = dbl << s; lo = dbl[63:32]; end
      4'd8:  lo = a & b;
      4'd9:  lo = a | b;
      4'd10: lo = -a;
      4'd11: lo = ~a;
      4'd12: lo = $signed(a) >>> s;
      4'd13: lo = a ^ b;
      default: begin hi = 0; lo = 0; end
    endcase
  endtask

  // Issue one op and wait for done. lat counts rising edges from the accept
  // edge (counted as 1) up to the edge after which done is seen.
  task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output logic dz, output int lat, output int bcyc);
    @(negedge clk);
    ctrl = c; A = a; B = b; start = 1'b1;
    @(posedge clk);
    lat = 1; bcyc = 0;
    #1 start = 1'b0;
    @(negedge clk);
    while (!done && lat < 100) begin
      if (busy) bcyc++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!done) chk("done_timeout", 64'(done), 64'd1);
    hi = ZHI; lo = ZLO; dz = div_by_zero;
    @(negedge clk);
    chk("done_pulse_width", 64'(done), 64'd0);
  endtask

  vec_t        vecs[$];
  logic [31:0] g_hi, g_lo, e_hi, e_lo;
  logic        g_dz, e_dz;
  int          g_lat, e_lat, g_bc;

  initial begin
    clr = 1'b1; start = 1'b0; ctrl = 4'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_zhi", 64'(ZHI), 64'd0);
    chk("rst_zlo", 64'(ZLO), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    clr = 1'b0;

    // Directed table: {ctrl, A, B, ZHI, ZLO, dbz, latency, busy cycles}
    vecs.push_back('{4'd0,  32'hFFFFFFFF, 32'd1,        32'h0,        32'h00000000, 1'b0, 1,  0});
    vecs.push_back('{4'd2,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 32});
    vecs.push_back('{4'd3,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 32});
    vecs.push_back('{4'd3,  32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 33, 32});
    vecs.push_back('{4'd3,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 1,  0});
    vecs.push_back('{4'd7,  32'h80000001, 32'd4,        32'h0,        32'h00000018, 1'b0, 1,  0});
    vecs.push_back('{4'd12, 32'h80000000, 32'd31,       32'h0,        32'hFFFFFFFF, 1'b0, 1,  0});
    vecs.push_back('{4'd14, 32'h12345678, 32'd9,        32'h0,        32'h0,        1'b0, 1,  0});
    vecs.push_back('{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b0, 1,  0});
    vecs.push_back('{4'd6,  32'h00000001, 32'd1,        32'h0,        32'h80000000, 1'b0, 1,  0});
    vecs.push_back('{4'd5,  32'hA5A5A5A5, 32'h20,       32'h0,        32'hA5A5A5A5, 1'b0, 1,  0});
    vecs.push_back('{4'd10, 32'd1,        32'd0,        32'h0,        32'hFFFFFFFF, 1'b0, 1,  0});
    vecs.push_back('{4'd2,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0, 33, 32});
    vecs.push_back('{4'd1,  32'd0,        32'd1,        32'h0,        32'hFFFFFFFF, 1'b0, 1,  0});
    vecs.push_back('{4'd3,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33, 32});

    foreach (vecs[i]) begin
      do_op(vecs[i].c, vecs[i].a, vecs[i].b, g_hi, g_lo, g_dz, g_lat, g_bc);
      chk($sformatf("vec%0d_zhi", i), 64'(g_hi), 64'(vecs[i].hi));
      chk($sformatf("vec%0d_zlo", i), 64'(g_lo), 64'(vecs[i].lo));
      chk($sformatf("vec%0d_dbz", i), 64'(g_dz), 64'(vecs[i].dz));
      chk($sformatf("vec%0d_lat", i), 64'(g_lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_busy", i), 64'(g_bc), 64'(vecs[i].bcyc));
    end

    // Randomized ops against the model.
    for (int i = 0; i < 150; i++) begin
      logic [3:0]  c;
      logic [31:0] a, b;
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0)  b = $urandom_range(0, 3);
      if (i % 9 == 0)  b = 32'hFFFFFFFF;
      if (i % 11 == 0) a = 32'h80000000;
      if (i % 13 == 0) b = 32'd0;
      model(c, a, b, e_hi, e_lo, e_dz, e_lat);
      do_op(c, a, b, g_hi, g_lo, g_dz, g_lat, g_bc);
      chk($sformatf("rnd%0d_op%0d_zhi", i, c), 64'(g_hi), 64'(e_hi));
      chk($sformatf("rnd%0d_op%0d_zlo", i, c), 64'(g_lo), 64'(e_lo));
      chk($sformatf("rnd%0d_op%0d_dbz", i, c), 64'(g_dz), 64'(e_dz));
      chk($sformatf("rnd%0d_op%0d_lat", i, c), 64'(g_lat), 64'(e_lat));
    end

    // MUL with a stray start pulse at cycle 5; result must be unaffected and
    // partial products must never appear on ZHI/ZLO.
    begin
      logic [31:0] p_hi, p_lo;
      int seen, leak, got_lat;
      seen = 0; leak = 0; got_lat = 0;
      @(negedge clk);
      p_hi = ZHI; p_lo = ZLO;
      ctrl = 4'd2; A = 32'hFFFFFFFD; B = 32'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 40 && seen == 0; k++) begin
        @(negedge clk);
        if (done) begin
          seen = 1; got_lat = k;
        end else if (ZLO !== p_lo || ZHI !== p_hi) begin
          leak = 1;
        end
        if (k == 5) begin
          start = 1'b1; ctrl = 4'd0; A = 32'd1; B = 32'd1;
        end else begin
          start = 1'b0;
        end
        @(posedge clk);
      end
      chk("pulse_mul_lat", 64'(got_lat), 64'd33);
      chk("pulse_mul_leak", 64'(leak), 64'd0);
      chk("pulse_mul_zhi", 64'(ZHI), 64'hFFFFFFFF);
      chk("pulse_mul_zlo", 64'(ZLO), 64'hFFFFFFEB);
      repeat (3) begin
        @(negedge clk);
        chk("pulse_no_extra_done", 64'(done), 64'd0);
      end
    end

    // Start held high through DONE must be ignored.
    @(negedge clk);
    ctrl = 4'd0; A = 32'd1; B = 32'd2; start = 1'b1;
    @(posedge clk);
    #1 A = 32'd10;
    @(negedge clk);
    chk("hold_done1", 64'(done), 64'd1);
    chk("hold_zlo1", 64'(ZLO), 64'd3);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("hold_done2", 64'(done), 64'd0);
    chk("hold_zlo2", 64'(ZLO), 64'd3);
    @(negedge clk);
    chk("hold_done3", 64'(done), 64'd0);

    // Abandon a MUL with clr at cycle 10.
    do_op(4'd0, 32'd5, 32'd6, g_hi, g_lo, g_dz, g_lat, g_bc);
    chk("pre_clr_zlo", 64'(g_lo), 64'd11);
    @(negedge clk);
    ctrl = 4'd2; A = 32'd100; B = 32'd100; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_mul_busy", 64'(busy), 64'd1);
    #2 clr = 1'b1;
    #1;
    chk("clr_zhi", 64'(ZHI), 64'd0);
    chk("clr_zlo", 64'(ZLO), 64'd0);
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_done", 64'(done), 64'd0);
    chk("clr_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    clr = 1'b0;
    begin
      int dseen;
      dseen = 0;
      repeat (40) begin
        @(negedge clk);
        if (done || busy) dseen++;
      end
      chk("clr_no_late_done", 64'(dseen), 64'd0);
    end

    // First edge after clr release with start high is accepted.
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; ctrl = 4'd0; A = 32'd2; B = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("post_clr_done", 64'(done), 64'd1);
    chk("post_clr_zlo", 64'(ZLO), 64'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
